dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of `data_memory`. It shares the single 1024 x 32 data memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/loader port. Arbitration is round-robin. The block adds byte-enable stores by sequencing a read-modify-write on the word-only memory, and returns read data through a one-cycle response pulse.

## Interface
- `ADDR_WIDTH`, 10, word address width; must match `data_memory`.
- `DATA_WIDTH`, 32, data width; byte-enable width is `DATA_WIDTH/8`.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `pN_req_valid`  in  1  request from port N (N = 0, 1).
- `pN_req_ready`  out  1  request accepted this cycle.
- `pN_req_write`  in  1  1 = store, 0 = load.
- `pN_req_addr`  in  ADDR_WIDTH  word address.
- `pN_req_wdata`  in  DATA_WIDTH  store data.
- `pN_req_be`  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- `pN_rsp_valid`  out  1  one-cycle completion pulse.
- `pN_rsp_rdata`  out  DATA_WIDTH  load data; valid with `pN_rsp_valid`.
- `mem_write`  out  1  to `data_memory.mem_write`.
- `mem_read`  out  1  to `data_memory.mem_read`.
- `mem_address`  out  ADDR_WIDTH  to `data_memory.address`.
- `mem_write_data`  out  DATA_WIDTH  to `data_memory.write_data`.
- `mem_read_data`  in  DATA_WIDTH  from `data_memory.read_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Memory contract:**
  - A write is committed on the edge where `mem_write` is sampled high.
  - `mem_read_data` is valid in the cycle after `mem_read` is sampled high.
  - `mem_read` and `mem_write` are never asserted together.
- **FSM states:** IDLE, RD_WAIT, MERGE, RESP.
- **IDLE arbitration:**
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted. The `last_grant` register resets to 1, so port 0 wins the first tie.
  - The granted port sees `pN_req_ready`=1 for that cycle only.
  - Address, wdata, be, write and port ID are latched on the acceptance edge.
- **IDLE memory drive** (combinational, from the granted port):
  - Load: `mem_read`=1, then go to RD_WAIT.
  - Store with be = all ones: `mem_write`=1 with wdata, then go to RESP.
  - Store with partial be (nonzero, not all ones): `mem_read`=1, then go to MERGE.
  - Store with be = 0: no memory access, then go to RESP.
- **RD_WAIT:** latch `mem_read_data` into the response data register, then go to RESP.
- **MERGE:**
  - Drive `mem_write`=1 to the latched address.
  - Merged data takes byte i from wdata where be[i]=1, otherwise from `mem_read_data`.
  - Then go to RESP.
- **RESP:**
  - `pN_rsp_valid`=1 for the latched port only, then go to IDLE.
  - `pN_rsp_rdata` = read data for a load, 0 for a store.
  - Both ports' `pN_rsp_rdata` are driven from one shared register.
  - `pN_req_ready`=0 in RESP; a new grant occurs in the next IDLE cycle.
- **Outside IDLE:** all memory strobes and all `pN_req_ready` are 0, except the RD_WAIT and MERGE actions above. Requesters hold their request stable until ready. Responses have no backpressure.
- **Reset:**
  - Outputs: `busy`, `pN_req_ready`, `pN_rsp_valid`, `mem_read` and `mem_write` are all 0. `mem_address`, `mem_write_data` and `pN_rsp_rdata` are 0.
  - State: FSM is in IDLE; `last_grant`=1.
  - Reset asserted mid-operation abandons the access with no response. A MERGE write is not performed in the reset cycle.

## Timing
Cycle 0 is the acceptance cycle.
- Full-word store: memory written at the end of cycle 0; `rsp_valid` in cycle 1.
- Load: `mem_read` in cycle 0, capture in cycle 1, `rsp_valid` with data in cycle 2.
- Partial store: `mem_read` in cycle 0, `mem_write` in cycle 1, `rsp_valid` in cycle 2.
- be=0 store: `rsp_valid` in cycle 1.
- Back-to-back: the next acceptance is at the earliest in the cycle after RESP.
- Throughput: one access per 2 cycles (full store) or 3 cycles (load or partial store).
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

## Test plan
- **Port 0 full store, then load:** p0 store addr 5, wdata DEADBEEF, be F, then p0 load addr 5 -> `mem_write` for one cycle; `p0_rsp_valid` at cycle 1; the load returns DEADBEEF at cycle 2; port 1 stays silent.
- **Partial store:** memory[10]=12345678; p1 store addr 10, wdata AABBCCDD, be 0101 -> exactly one `mem_read` then one `mem_write` of 12BB56DD; a subsequent load of addr 10 returns 12BB56DD.
- **Contention:** both ports issue loads (p0 addr 1, p1 addr 2) every cycle for 4 grants -> grant order 0,1,0,1; each response goes only to the owning port with the correct data.
- **Zero byte-enable store:** be=0 to addr 3 holding 0000FFFF -> no memory strobe; `rsp_valid` at cycle 1; addr 3 is still 0000FFFF.
- **Reset mid-operation:** assert reset during MERGE of a partial store to addr 7 holding 11111111 -> no `mem_write` and no `rsp_valid`; addr 7 is unchanged; all outputs are 0 and `busy` is 0 in the cycle after reset.
- **Power-up tie:** simultaneous first requests after reset -> port 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a word-only data memory.
// Byte-enable stores are sequenced as a read-modify-write.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req_valid,
  output logic                    p0_req_ready,
  input  logic                    p0_req_write,
  input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
  input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_req_be,
  output logic                    p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p0_rsp_rdata,
  input  logic                    p1_req_valid,
  output logic                    p1_req_ready,
  input  logic                    p1_req_write,
  input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
  input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_req_be,
  output logic                    p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p1_rsp_rdata,
  output logic                    mem_write,
  output logic                    mem_read,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    busy
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE, RESP} state_t;

  state_t                state, state_next;
  logic                  last_grant;
  logic                  grant_valid;
  logic                  grant_port;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  lat_port;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] merged;

  // Byte i from store data where enabled, otherwise from the word just read.
  always_comb begin
    merged = mem_read_data;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, arbitration and memory drive; reset forces every strobe low.
  always_comb begin
    state_next     = state;
    grant_valid    = 1'b0;
    grant_port     = p1_req_valid && (!p0_req_valid || !last_grant);
    sel_write      = grant_port ? p1_req_write : p0_req_write;
    sel_addr       = grant_port ? p1_req_addr  : p0_req_addr;
    sel_wdata      = grant_port ? p1_req_wdata : p0_req_wdata;
    sel_be         = grant_port ? p1_req_be    : p0_req_be;
    p0_req_ready   = 1'b0;
    p1_req_ready   = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = lat_addr;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          grant_valid  = 1'b1;
          p0_req_ready = !grant_port;
          p1_req_ready = grant_port;
          mem_address  = sel_addr;
          if (!sel_write) begin
            mem_read   = 1'b1;
            state_next = RD_WAIT;
          end else if (sel_be == '1) begin
            mem_write      = 1'b1;
            mem_write_data = sel_wdata;
            state_next     = RESP;
          end else if (sel_be != '0) begin
            mem_read   = 1'b1;
            state_next = MERGE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RD_WAIT: state_next = RESP;
      MERGE: begin
        mem_write      = 1'b1;
        mem_write_data = merged;
        state_next     = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) begin
      state_next     = IDLE;
      grant_valid    = 1'b0;
      p0_req_ready   = 1'b0;
      p1_req_ready   = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      rdata_q    <= '0;
    end else begin
      if (grant_valid) begin
        last_grant <= grant_port;
        lat_port   <= grant_port;
        lat_write  <= sel_write;
        lat_addr   <= sel_addr;
        lat_wdata  <= sel_wdata;
        lat_be     <= sel_be;
        rdata_q    <= '0;
      end
      if (state == RD_WAIT) rdata_q <= lat_write ? '0 : mem_read_data;
    end
  end

  assign busy         = !reset && (state != IDLE);
  assign p0_rsp_valid = !reset && (state == RESP) && !lat_port;
  assign p1_rsp_valid = !reset && (state == RESP) && lat_port;
  assign p0_rsp_rdata = reset ? '0 : rdata_q;
  assign p1_rsp_rdata = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [9:0]  p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic [3:0]  p0_req_be;
  logic        p0_rsp_valid;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [9:0]  p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic [3:0]  p1_req_be;
  logic        p1_rsp_valid;
  logic [31:0] p1_rsp_rdata;
  logic        mem_write, mem_read;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_be(p0_req_be),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_be(p1_req_be),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Word memory: write on the sampled edge, registered read data; pre_we is a backdoor load.
  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_address] <= mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_be = '0;
    p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_be = '0;
  endtask

  task automatic req(input int port, input logic wr, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = a; p0_req_wdata = d; p0_req_be = be;
    end else begin
      p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = a; p1_req_wdata = d; p1_req_be = be;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rd"}, 32'(mem_read), 32'd0);
    chk({tag, ".wr"}, 32'(mem_write), 32'd0);
    chk({tag, ".rdy"}, {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    cyc();
    pre_we = 1'b1; pre_addr = a; pre_data = d;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    preload(10'd1,  32'h1111_0001);
    preload(10'd2,  32'h2222_0002);
    preload(10'd3,  32'h0000_FFFF);
    preload(10'd7,  32'h1111_1111);
    preload(10'd10, 32'h1234_5678);
    cyc(); pre_we = 1'b0; settle();
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    chk("reset.addr", 32'(mem_address), 32'd0);
    chk("reset.wdata", mem_write_data, 32'd0);
    chk("reset.rdata", p0_rsp_rdata, 32'd0);
    chk_quiet("reset");

    // Power-up tie and contention: both ports load every cycle, grants 0,1,0,1.
    cyc(); reset = 1'b0;
    req(0, 1'b0, 10'd1, 32'd0, 4'h0);
    req(1, 1'b0, 10'd2, 32'd0, 4'h0);
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("cont.rdy", {30'd0, p1_req_ready, p0_req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont.rd", 32'(mem_read), 32'd1);
      chk("cont.addr", 32'(mem_address), (g % 2 == 0) ? 32'd1 : 32'd2);
      cyc(); settle();
      chk_quiet("cont.wait");
      chk("cont.busy", 32'(busy), 32'd1);
      cyc(); settle();
      chk("cont.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont.data", (g % 2 == 0) ? p0_rsp_rdata : p1_rsp_rdata,
          (g % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002);
      chk_quiet("cont.resp");
      cyc();
    end
    idle_inputs(); settle();
    chk("idle.busy", 32'(busy), 32'd0);

    // Port 0 full-word store then load back.
    cyc(); req(0, 1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF); settle();
    chk("fst.rdy", {30'd0, p1_req_ready, p0_req_ready}, 32'd1);
    chk("fst.wr", 32'(mem_write), 32'd1);
    chk("fst.rd", 32'(mem_read), 32'd0);
    chk("fst.addr", 32'(mem_address), 32'd5);
    chk("fst.wdata", mem_write_data, 32'hDEAD_BEEF);
    cyc(); idle_inputs(); settle();
    chk("fst.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd1);
    chk("fst.rdata", p0_rsp_rdata, 32'd0);
    chk("fst.mem", mem[5], 32'hDEAD_BEEF);
    chk_quiet("fst.resp");
    cyc(); req(0, 1'b0, 10'd5, 32'd0, 4'h0); settle();
    chk("ld5.rd", 32'(mem_read), 32'd1);
    cyc(); idle_inputs(); settle();
    chk("ld5.wait", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    cyc(); settle();
    chk("ld5.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd1);
    chk("ld5.data", p0_rsp_rdata, 32'hDEAD_BEEF);

    // Port 1 partial store: read then merged write.
    cyc(); req(1, 1'b1, 10'd10, 32'hAABB_CCDD, 4'b0101); settle();
    chk("pst.rdy", {30'd0, p1_req_ready, p0_req_ready}, 32'd2);
    chk("pst.rd", 32'(mem_read), 32'd1);
    chk("pst.wr0", 32'(mem_write), 32'd0);
    cyc(); idle_inputs(); settle();
    chk("pst.wr1", 32'(mem_write), 32'd1);
    chk("pst.rd1", 32'(mem_read), 32'd0);
    chk("pst.addr", 32'(mem_address), 32'd10);
    chk("pst.wdata", mem_write_data, 32'h12BB_56DD);
    chk("pst.early", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    cyc(); settle();
    chk("pst.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd2);
    chk("pst.rdata", p1_rsp_rdata, 32'd0);
    chk("pst.mem", mem[10], 32'h12BB_56DD);
    chk_quiet("pst.resp");
    cyc(); req(1, 1'b0, 10'd10, 32'd0, 4'h0); settle();
    cyc(); idle_inputs();
    cyc(); settle();
    chk("ld10.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd2);
    chk("ld10.data", p1_rsp_rdata, 32'h12BB_56DD);

    // Zero byte-enable store touches nothing.
    cyc(); req(0, 1'b1, 10'd3, 32'hFFFF_FFFF, 4'h0); settle();
    chk("zbe.rdy", {30'd0, p1_req_ready, p0_req_ready}, 32'd1);
    chk("zbe.strobe", {30'd0, mem_write, mem_read}, 32'd0);
    cyc(); idle_inputs(); settle();
    chk("zbe.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd1);
    chk("zbe.mem", mem[3], 32'h0000_FFFF);

    // Reset during MERGE abandons the store.
    cyc(); req(1, 1'b1, 10'd7, 32'h2222_2222, 4'b0011); settle();
    chk("rmid.rd", 32'(mem_read), 32'd1);
    cyc(); idle_inputs(); reset = 1'b1; settle();
    chk("rmid.wr", 32'(mem_write), 32'd0);
    chk("rmid.rspv", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    cyc(); reset = 1'b0; settle();
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.rspv2", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    chk("rmid.addr", 32'(mem_address), 32'd0);
    chk("rmid.wdata", mem_write_data, 32'd0);
    chk("rmid.rdata", p1_rsp_rdata, 32'd0);
    chk_quiet("rmid");
    chk("rmid.mem", mem[7], 32'h1111_1111);
    cyc(); settle();
    chk("rmid.late", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);

    // After reset the tie goes to port 0 again.
    cyc(); req(0, 1'b0, 10'd1, 32'd0, 4'h0); req(1, 1'b0, 10'd2, 32'd0, 4'h0); settle();
    chk("tie2.rdy", {30'd0, p1_req_ready, p0_req_ready}, 32'd1);
    cyc(); idle_inputs();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
